// File: rtl/if_pkg.sv
// Shared constants for the IF stage: FSM encoding, bubble word and the
// default instruction-memory map (also reused by MEM_INST and its bench).
package if_pkg;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  typedef enum logic [1:0] {
    ST_BOOT = BOOT,
    ST_RUN  = RUN,
    ST_HALT = HALT
  } state_e;

  // addi x0,x0,0
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0400;
  localparam logic [31:0] DEF_MEM_BASE  = 32'h0000_0400;
  localparam logic [31:0] DEF_MEM_LIMIT = 32'h0000_1000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Reset clears the slot, bubble replaces the
// instruction with a NOP and marks it invalid, load captures a fetched
// word, and otherwise the register holds (stall).
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] instr_q;
  logic        valid_q;

  // Slot update: reset > bubble > load > hold. Bubbles keep the PC fields.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q    <= 32'd0;
      pc4_q   <= 32'd0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (i_bubble) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (i_load) begin
      pc_q    <= i_pc;
      pc4_q   <= i_pc + 32'd4;
      instr_q <= i_instr;
      valid_q <= 1'b1;
    end
  end

  assign o_pc    = pc_q;
  assign o_pc4   = pc4_q;
  assign o_instr = instr_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/if_pc_stage.sv
// Fetch-stage front end: program counter, range check and BOOT/RUN/HALT
// control, feeding the IF/ID register. The memory is zero-latency, so the
// word on i_instruccion always belongs to the current o_pc.
// Optional build macro IF_MISALIGN_CHECK_EN: reject redirects whose target
// is not word aligned (fault + one-cycle o_misalign pulse) instead of
// silently clearing the two low bits.
module if_pc_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] MEM_BASE  = DEF_MEM_BASE,
  parameter logic [31:0] MEM_LIMIT = DEF_MEM_LIMIT,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic [31:0] i_instruccion,
  output logic [31:0] o_pc,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_pc4,
  output logic [31:0] o_id_instruccion,
  output logic        o_id_valid,
  output logic        o_fault
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        o_misalign
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic        id_load;
  logic        id_bubble;
  logic        in_range;
  logic        misaligned;
  logic        reject;
  logic [31:0] redir_target;

  assign in_range = (pc_q >= MEM_BASE) && (pc_q < MEM_LIMIT);

`ifdef IF_MISALIGN_CHECK_EN
  assign misaligned   = (i_redirect_pc[1:0] != 2'b00);
  assign redir_target = i_redirect_pc;
`else
  assign misaligned   = 1'b0;
  assign redir_target = i_redirect_pc & ~32'h0000_0003;
`endif

  // A rejected redirect is treated as a fetch fault.
  assign reject = i_redirect && misaligned;

  // Next-state/control: redirect > fault > stall > advance.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    case (state_q)
      ST_BOOT: begin
        id_bubble = 1'b1;
        state_d   = ST_RUN;
        if (reject) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else if (i_redirect) begin
          pc_d = redir_target;
        end
      end
      ST_RUN: begin
        if (reject) begin
          id_bubble = 1'b1;
          fault_d   = 1'b1;
          state_d   = ST_HALT;
        end else if (i_redirect) begin
          id_bubble = 1'b1;
          pc_d      = redir_target;
        end else if (!in_range) begin
          id_bubble = 1'b1;
          fault_d   = 1'b1;
          state_d   = ST_HALT;
        end else if (!i_stall) begin
          id_load = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
      ST_HALT: begin
        id_bubble = 1'b1;
        fault_d   = 1'b1;
        if (i_redirect && !reject) begin
          pc_d    = redir_target;
          fault_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        id_bubble = 1'b1;
        state_d   = ST_BOOT;
      end
    endcase
  end

  // State, PC and fault registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q;

  // One-cycle flag for each rejected redirect.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= reject;
    end
  end

  assign o_misalign = misalign_q;
`endif

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (id_load),
    .i_bubble (id_bubble),
    .i_pc     (pc_q),
    .i_instr  (i_instruccion),
    .o_pc     (o_id_pc),
    .o_pc4    (o_id_pc4),
    .o_instr  (o_id_instruccion),
    .o_valid  (o_id_valid)
  );

  assign o_pc    = pc_q;
  assign o_fault = fault_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// Bench for if_pc_stage: directed stimulus, a behavioural fetch model that is
// compared against the DUT every cycle, and literal pins on key cycles.
module tb_if_pc_stage;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'd0;
  logic [31:0] i_instruccion;
  logic [31:0] o_pc;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_pc4;
  logic [31:0] o_id_instruccion;
  logic        o_id_valid;
  logic        o_fault;
`ifdef IF_MISALIGN_CHECK_EN
  logic        o_misalign;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: easy-to-read word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  assign i_instruccion = mem_word(o_pc);

  if_pc_stage dut (
    .i_clk            (clk),
    .i_rst_n          (i_rst_n),
    .i_stall          (i_stall),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .i_instruccion    (i_instruccion),
    .o_pc             (o_pc),
    .o_id_pc          (o_id_pc),
    .o_id_pc4         (o_id_pc4),
    .o_id_instruccion (o_id_instruccion),
    .o_id_valid       (o_id_valid),
    .o_fault          (o_fault)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .o_misalign       (o_misalign)
`endif
  );

  // Model state: where fetch is, whether it is stopped, and what ID holds.
  logic [31:0] m_pc     = 32'h400;
  bit          m_boot   = 1'b1;
  bit          m_halted = 1'b0;
  bit          m_valid  = 1'b0;
  bit          m_mis    = 1'b0;
  logic [31:0] m_id_pc    = 32'd0;
  logic [31:0] m_id_pc4   = 32'd0;
  logic [31:0] m_id_instr = 32'h13;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit bad_align(input logic [31:0] t);
`ifdef IF_MISALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Apply one cycle of inputs, predict the outcome, and advance one edge.
  task automatic cyc(input bit r, input bit s, input bit d, input logic [31:0] t);
    logic [31:0] n_pc = m_pc, n_id_pc = m_id_pc, n_id_pc4 = m_id_pc4, n_instr = m_id_instr;
    bit n_boot = m_boot, n_halted = m_halted, n_valid = m_valid, n_mis = 1'b0;
    i_rst_n = r; i_stall = s; i_redirect = d; i_redirect_pc = t;
    if (!r) begin
      n_pc = 32'h400; n_boot = 1; n_halted = 0; n_valid = 0;
      n_id_pc = 0; n_id_pc4 = 0; n_instr = 32'h13;
    end else if (d && bad_align(t)) begin
      n_valid = 0; n_instr = 32'h13; n_halted = 1; n_mis = 1; n_boot = 0;
    end else if (d) begin
      n_valid = 0; n_instr = 32'h13; n_pc = {t[31:2], 2'b00}; n_halted = 0; n_boot = 0;
    end else if (m_boot || m_halted) begin
      n_valid = 0; n_instr = 32'h13; n_boot = 0;
    end else if (m_pc < 32'h400 || m_pc >= 32'h1000) begin
      n_valid = 0; n_instr = 32'h13; n_halted = 1;
    end else if (!s) begin
      n_valid = 1; n_id_pc = m_pc; n_id_pc4 = m_pc + 32'd4;
      n_instr = mem_word(m_pc); n_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    m_pc = n_pc; m_boot = n_boot; m_halted = n_halted; m_valid = n_valid; m_mis = n_mis;
    m_id_pc = n_id_pc; m_id_pc4 = n_id_pc4; m_id_instr = n_instr;
    #2;
    $display("cyc rst_n=%0b stall=%0b redir=%0b tgt=%h -> pc=%h id_pc=%h instr=%h v=%0b fault=%0b",
             r, s, d, t, o_pc, o_id_pc, o_id_instruccion, o_id_valid, o_fault);
  endtask

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", o_pc, m_pc);
      chk("id_valid", {31'd0, o_id_valid}, {31'd0, m_valid});
      chk("id_instr", o_id_instruccion, m_id_instr);
      chk("fault", {31'd0, o_fault}, {31'd0, m_halted});
      if (m_valid) begin
        chk("id_pc", o_id_pc, m_id_pc);
        chk("id_pc4", o_id_pc4, m_id_pc4);
      end
`ifdef IF_MISALIGN_CHECK_EN
      chk("misalign", {31'd0, o_misalign}, {31'd0, m_mis});
`endif
    end
  end

  initial begin
    cyc(0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(0, 0, 0, 0);
    chk("rst_pc", o_pc, 32'h400);
    chk("rst_valid", {31'd0, o_id_valid}, 32'd0);
    chk("rst_instr", o_id_instruccion, 32'h13);
    chk("rst_id_pc", o_id_pc, 32'd0);
    chk("rst_id_pc4", o_id_pc4, 32'd0);
    chk("rst_fault", {31'd0, o_fault}, 32'd0);

    cyc(1, 0, 0, 0);  // BOOT bubble
    chk("boot_pc", o_pc, 32'h400);
    chk("boot_valid", {31'd0, o_id_valid}, 32'd0);
    cyc(1, 0, 0, 0);  // first fetch latched
    chk("first_id_pc", o_id_pc, 32'h400);
    chk("first_instr", o_id_instruccion, 32'h0400C0DE);
    chk("first_valid", {31'd0, o_id_valid}, 32'd1);
    chk("first_pc", o_pc, 32'h404);

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    chk("stall_pc", o_pc, 32'h408);
    chk("stall_id_pc", o_id_pc, 32'h404);
    cyc(1, 0, 0, 0);
    chk("unstall_id_pc", o_id_pc, 32'h408);
    chk("unstall_id_pc4", o_id_pc4, 32'h40C);
    chk("unstall_pc", o_pc, 32'h40C);

    cyc(1, 1, 1, 32'h500);  // redirect beats stall
    chk("redir_pc", o_pc, 32'h500);
    chk("redir_valid", {31'd0, o_id_valid}, 32'd0);
    chk("redir_instr", o_id_instruccion, 32'h13);
    cyc(1, 0, 0, 0);
    chk("redir_id_pc", o_id_pc, 32'h500);

    cyc(1, 0, 1, 32'h1000);  // just past the top of memory
    chk("lim_nofault", {31'd0, o_fault}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("lim_fault", {31'd0, o_fault}, 32'd1);
    chk("lim_pc", o_pc, 32'h1000);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 32'h400);
    chk("resume_fault", {31'd0, o_fault}, 32'd0);
    chk("resume_pc", o_pc, 32'h400);
    cyc(1, 0, 0, 0);

    cyc(1, 0, 1, 32'h1000);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 32'h800);  // reset wins over redirect in HALT
    chk("halt_rst_pc", o_pc, 32'h400);
    chk("halt_rst_fault", {31'd0, o_fault}, 32'd0);
    chk("halt_rst_id_pc", o_id_pc, 32'd0);
    cyc(1, 0, 1, 32'h600);  // redirect during BOOT
    chk("boot_redir_pc", o_pc, 32'h600);
    cyc(1, 0, 0, 0);

    cyc(1, 0, 1, 32'h402);
`ifdef IF_MISALIGN_CHECK_EN
    chk("mis_pulse", {31'd0, o_misalign}, 32'd1);
    chk("mis_fault", {31'd0, o_fault}, 32'd1);
    cyc(1, 0, 0, 0);
    chk("mis_clear", {31'd0, o_misalign}, 32'd0);
`else
    chk("align_pc", o_pc, 32'h400);
    chk("align_fault", {31'd0, o_fault}, 32'd0);
    cyc(1, 0, 0, 0);
`endif

    cyc(1, 0, 1, 32'h3FC);  // just below the base
    cyc(1, 0, 0, 0);
    chk("base_fault", {31'd0, o_fault}, 32'd1);
    cyc(1, 0, 1, 32'hFFC);  // last valid word
    cyc(1, 0, 0, 0);
    chk("top_id_pc", o_id_pc, 32'hFFC);
    chk("top_pc", o_pc, 32'h1000);
    chk("top_nofault", {31'd0, o_fault}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("top_fault", {31'd0, o_fault}, 32'd1);
    cyc(1, 0, 0, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
